// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, falling-edge start detect,
// three-tick majority vote per bit, optional parity, one-cycle valid strobe.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVS        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxen,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVS);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_V0  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_V1  = TW'(OVS/2);
  localparam logic [TW-1:0] T_V2  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p ^ (PARITY_ODD != 0);
  endfunction

  state_e                 state_q, state_d;
  logic                   sync1_q, rs_q, rs_dly_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   smp0_q, smp0_d, smp1_q, smp1_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;

  logic vote, fall, at_vote, at_end;

  assign vote    = maj3(smp0_q, smp1_q, rs_q);
  assign fall    = rs_dly_q & ~rs_q;
  assign at_vote = rxen && (tick_q == T_V2);
  assign at_end  = rxen && (tick_q == T_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rs_q         <= 1'b1;
      rs_dly_q     <= 1'b1;
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      smp0_q       <= 1'b0;
      smp1_q       <= 1'b0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync1_q      <= rxd;
      rs_q         <= sync1_q;
      rs_dly_q     <= rs_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      smp0_q       <= smp0_d;
      smp1_q       <= smp1_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Start-bit falling edges are only honoured in IDLE; a held-low line after a
  // break produces no new edge until the line has gone high again.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fall) state_d = S_START;
      S_START:  begin
        if (at_vote && vote) state_d = S_IDLE;
        else if (at_end)     state_d = S_DATA;
      end
      S_DATA:   if (at_end && bit_q == B_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_d = S_STOP;
      S_STOP:   if (at_vote) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_d       = tick_q;
    bit_d        = bit_q;
    smp0_d       = smp0_q;
    smp1_d       = smp1_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    if (state_q == S_IDLE) begin
      tick_d = '0;
      bit_d  = '0;
    end else if (rxen) begin
      tick_d = tick_q + 1'b1;
      if (tick_q == T_V0) smp0_d = rs_q;
      if (tick_q == T_V1) smp1_d = rs_q;
    end
    if (state_q == S_DATA && at_vote) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
    if (state_q == S_DATA && at_end)  bit_d = bit_q + 1'b1;
    if (state_q == S_PARITY && at_vote) par_d = vote;
    if (state_q == S_STOP && at_vote) begin
      rx_data_d    = shreg_q;
      rx_valid_d   = 1'b1;
      frame_err_d  = ~vote;
      parity_err_d = (PARITY_EN != 0) ? par_mismatch(shreg_q, par_q) : 1'b0;
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule
